// File: rtl/id_ex_pkg.sv
// Shared widths, control-bundle type and bubble constant for the ID/EX pipeline register.
package id_ex_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned WB_W        = 2;
  localparam int unsigned M_W         = 3;
  localparam int unsigned EX_W        = 4;
  localparam int unsigned MEMREAD_BIT = 1;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard.sv
// Combinational load-use comparator: a valid load in EX whose rt feeds the ID instruction.
module id_ex_hazard #(
  parameter int unsigned REG_W = id_ex_pkg::REG_W
) (
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hazard
);

  always_comb begin
    hazard = ex_valid & ex_memread & id_valid & (ex_rt != '0) &
             ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid, stall, flush, bubble counter and optional
// load-use bubble insertion (enabled by defining ID_EX_LOAD_USE_EN).
module id_ex_pipe
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W      = id_ex_pkg::DATA_W,
  parameter int unsigned REG_W       = id_ex_pkg::REG_W,
  parameter int unsigned WB_W        = id_ex_pkg::WB_W,
  parameter int unsigned M_W         = id_ex_pkg::M_W,
  parameter int unsigned EX_W        = id_ex_pkg::EX_W,
  parameter int unsigned MEMREAD_BIT = id_ex_pkg::MEMREAD_BIT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [WB_W-1:0]   id_wb_i,
  input  logic [M_W-1:0]    id_m_i,
  input  logic [EX_W-1:0]   id_ex_i,
  input  logic [DATA_W-1:0] id_npc_i,
  input  logic [DATA_W-1:0] id_rdata1_i,
  input  logic [DATA_W-1:0] id_rdata2_i,
  input  logic [DATA_W-1:0] id_sext_i,
  input  logic [REG_W-1:0]  id_rs_i,
  input  logic [REG_W-1:0]  id_rt_i,
  input  logic [REG_W-1:0]  id_rd_i,
  output logic              ex_valid_o,
  output logic [WB_W-1:0]   ex_wb_o,
  output logic [M_W-1:0]    ex_m_o,
  output logic [EX_W-1:0]   ex_ex_o,
  output logic [DATA_W-1:0] ex_npc_o,
  output logic [DATA_W-1:0] ex_rdata1_o,
  output logic [DATA_W-1:0] ex_rdata2_o,
  output logic [DATA_W-1:0] ex_sext_o,
  output logic [REG_W-1:0]  ex_rs_o,
  output logic [REG_W-1:0]  ex_rt_o,
  output logic [REG_W-1:0]  ex_rd_o,
  output logic              hazard_stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic load_use;
  logic bubble;
  logic load;

`ifdef ID_EX_LOAD_USE_EN
  id_ex_hazard #(
    .REG_W (REG_W)
  ) u_hazard (
    .ex_valid   (ex_valid_o),
    .ex_memread (ex_m_o[MEMREAD_BIT]),
    .ex_rt      (ex_rt_o),
    .id_valid   (id_valid_i),
    .id_rs      (id_rs_i),
    .id_rt      (id_rt_i),
    .hazard     (load_use)
  );
`else
  assign load_use = 1'b0;
`endif

  assign hazard_stall_o = load_use;

  // flush beats stall; a load-use bubble only applies when not held
  always_comb begin
    bubble = flush_i | (~stall_i & load_use);
    load   = bubble | ~stall_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o   <= 1'b0;
      ex_wb_o      <= '0;
      ex_m_o       <= '0;
      ex_ex_o      <= '0;
      ex_npc_o     <= '0;
      ex_rdata1_o  <= '0;
      ex_rdata2_o  <= '0;
      ex_sext_o    <= '0;
      ex_rs_o      <= '0;
      ex_rt_o      <= '0;
      ex_rd_o      <= '0;
      bubble_cnt_o <= '0;
    end else if (load) begin
      ex_npc_o    <= id_npc_i;
      ex_rdata1_o <= id_rdata1_i;
      ex_rdata2_o <= id_rdata2_i;
      ex_sext_o   <= id_sext_i;
      ex_rs_o     <= id_rs_i;
      ex_rt_o     <= id_rt_i;
      ex_rd_o     <= id_rd_i;
      if (bubble) begin
        ex_valid_o <= 1'b0;
        ex_wb_o    <= '0;
        ex_m_o     <= '0;
        ex_ex_o    <= '0;
        if (bubble_cnt_o != '1)
          bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end else begin
        ex_valid_o <= id_valid_i;
        ex_wb_o    <= id_wb_i;
        ex_m_o     <= id_m_i;
        ex_ex_o    <= id_ex_i;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe; a second instance with CNT_W=2 checks saturation.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, id_valid_i;
  logic [1:0]  id_wb_i;
  logic [2:0]  id_m_i;
  logic [3:0]  id_ex_i;
  logic [31:0] id_npc_i, id_rdata1_i, id_rdata2_i, id_sext_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;

  logic        ex_valid_o;
  logic [1:0]  ex_wb_o;
  logic [2:0]  ex_m_o;
  logic [3:0]  ex_ex_o;
  logic [31:0] ex_npc_o, ex_rdata1_o, ex_rdata2_o, ex_sext_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
  logic        hazard_stall_o;
  logic [15:0] bubble_cnt_o;

  logic        s_valid;
  logic [1:0]  s_wb;
  logic [2:0]  s_m;
  logic [3:0]  s_ex;
  logic [31:0] s_npc, s_rdata1, s_rdata2, s_sext;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic        s_hazard;
  logic [1:0]  s_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] cnt_before;
  logic        exp_hz;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_wb_i(id_wb_i), .id_m_i(id_m_i), .id_ex_i(id_ex_i),
    .id_npc_i(id_npc_i), .id_rdata1_i(id_rdata1_i), .id_rdata2_i(id_rdata2_i),
    .id_sext_i(id_sext_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .ex_valid_o(ex_valid_o), .ex_wb_o(ex_wb_o), .ex_m_o(ex_m_o), .ex_ex_o(ex_ex_o),
    .ex_npc_o(ex_npc_o), .ex_rdata1_o(ex_rdata1_o), .ex_rdata2_o(ex_rdata2_o),
    .ex_sext_o(ex_sext_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .hazard_stall_o(hazard_stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_wb_i(id_wb_i), .id_m_i(id_m_i), .id_ex_i(id_ex_i),
    .id_npc_i(id_npc_i), .id_rdata1_i(id_rdata1_i), .id_rdata2_i(id_rdata2_i),
    .id_sext_i(id_sext_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .ex_valid_o(s_valid), .ex_wb_o(s_wb), .ex_m_o(s_m), .ex_ex_o(s_ex),
    .ex_npc_o(s_npc), .ex_rdata1_o(s_rdata1), .ex_rdata2_o(s_rdata2),
    .ex_sext_o(s_sext), .ex_rs_o(s_rs), .ex_rt_o(s_rt), .ex_rd_o(s_rd),
    .hazard_stall_o(s_hazard), .bubble_cnt_o(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    stall_i = 0; flush_i = 0; id_valid_i = 0;
    id_wb_i = '0; id_m_i = '0; id_ex_i = '0;
    id_npc_i = '0; id_rdata1_i = '0; id_rdata2_i = '0; id_sext_i = '0;
    id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    id_valid_i = 1; id_wb_i = 2'b11; id_m_i = 3'b010; id_npc_i = 32'h55;
    tick(); tick();
    n_checks++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h want 0", ex_valid_o); end
    n_checks++; if (ex_wb_o !== 2'b00 || ex_m_o !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got wb=%0h m=%0h want 0", ex_wb_o, ex_m_o); end
    n_checks++; if (ex_npc_o !== 32'h0) begin n_fail++; $display("FAIL reset_npc got %0h want 0", ex_npc_o); end
    n_checks++; if (bubble_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %0h want 0", bubble_cnt_o); end
    n_checks++; if (hazard_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %0h want 0", hazard_stall_o); end
    rst_n = 1;
    drive_idle();
  endtask

  task automatic test_normal();
    id_npc_i = 32'h04; id_rdata1_i = 32'hDEADBEEF; id_wb_i = 2'b11; id_valid_i = 1;
    id_rd_i = 5'd9; id_sext_i = 32'hFFFF_FFF0;
    tick();
    n_checks++; if (ex_npc_o !== 32'h04) begin n_fail++; $display("FAIL load_npc got %0h want 4", ex_npc_o); end
    n_checks++; if (ex_rdata1_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata1 got %0h want deadbeef", ex_rdata1_o); end
    n_checks++; if (ex_wb_o !== 2'b11) begin n_fail++; $display("FAIL load_wb got %0h want 3", ex_wb_o); end
    n_checks++; if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL load_valid got %0h want 1", ex_valid_o); end
    n_checks++; if (ex_rd_o !== 5'd9 || ex_sext_o !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL load_rd_sext got rd=%0d sext=%0h want 9 fffffff0", ex_rd_o, ex_sext_o); end
  endtask

  task automatic test_stall();
    id_npc_i = 32'h100; id_rdata2_i = 32'hA; id_ex_i = 4'h5; id_valid_i = 1;
    tick();
    cnt_before = bubble_cnt_o;
    stall_i = 1;
    id_npc_i = 32'h200; id_rdata2_i = 32'hB; id_ex_i = 4'hC; id_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (ex_npc_o !== 32'h100 || ex_rdata2_o !== 32'hA || ex_ex_o !== 4'h5 || ex_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d] got npc=%0h rd2=%0h ex=%0h v=%0h want 100 a 5 1", i, ex_npc_o, ex_rdata2_o, ex_ex_o, ex_valid_o);
      end
    end
    n_checks++; if (bubble_cnt_o !== cnt_before) begin n_fail++; $display("FAIL stall_cnt got %0d want %0d", bubble_cnt_o, cnt_before); end
    stall_i = 0;
    tick();
    n_checks++; if (ex_npc_o !== 32'h200 || ex_rdata2_o !== 32'hB || ex_ex_o !== 4'hC || ex_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_release got npc=%0h rd2=%0h ex=%0h v=%0h want 200 b c 0", ex_npc_o, ex_rdata2_o, ex_ex_o, ex_valid_o);
    end
  endtask

  task automatic test_flush_stall();
    id_valid_i = 1; id_wb_i = 2'b10; id_m_i = 3'b101; id_ex_i = 4'hF; id_npc_i = 32'h40;
    tick();
    cnt_before = bubble_cnt_o;
    stall_i = 1; flush_i = 1; id_npc_i = 32'h44;
    tick();
    stall_i = 0; flush_i = 0;
    n_checks++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0h want 0", ex_valid_o); end
    n_checks++; if (ex_wb_o !== 2'b00 || ex_m_o !== 3'b000 || ex_ex_o !== 4'h0) begin
      n_fail++; $display("FAIL flush_ctrl got wb=%0h m=%0h ex=%0h want 0 0 0", ex_wb_o, ex_m_o, ex_ex_o);
    end
    n_checks++; if (bubble_cnt_o !== cnt_before + 16'd1) begin n_fail++; $display("FAIL flush_cnt got %0d want %0d", bubble_cnt_o, cnt_before + 16'd1); end
    n_checks++; if (ex_npc_o !== 32'h44) begin n_fail++; $display("FAIL flush_datapath got %0h want 44", ex_npc_o); end
  endtask

  task automatic test_load_use();
`ifdef ID_EX_LOAD_USE_EN
    exp_hz = 1'b1;
`else
    exp_hz = 1'b0;
`endif
    drive_idle();
    id_valid_i = 1; id_m_i = 3'b010; id_wb_i = 2'b01; id_rt_i = 5'd8; id_rs_i = 5'd1; id_npc_i = 32'h80;
    tick();
    cnt_before = bubble_cnt_o;
    id_m_i = 3'b000; id_wb_i = 2'b11; id_rs_i = 5'd8; id_rt_i = 5'd3; id_npc_i = 32'h300;
    #1;
    n_checks++; if (hazard_stall_o !== exp_hz) begin n_fail++; $display("FAIL lu_hazard got %0h want %0h", hazard_stall_o, exp_hz); end
    tick();
    n_checks++; if (ex_valid_o !== ~exp_hz || ex_npc_o !== 32'h300) begin
      n_fail++; $display("FAIL lu_bubble got v=%0h npc=%0h want %0h 300", ex_valid_o, ex_npc_o, ~exp_hz);
    end
    n_checks++; if (bubble_cnt_o !== cnt_before + {15'd0, exp_hz}) begin
      n_fail++; $display("FAIL lu_cnt got %0d want %0d", bubble_cnt_o, cnt_before + {15'd0, exp_hz});
    end
    n_checks++; if (hazard_stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_clear got %0h want 0", hazard_stall_o); end
    tick();
    n_checks++; if (ex_valid_o !== 1'b1 || ex_wb_o !== 2'b11) begin
      n_fail++; $display("FAIL lu_advance got v=%0h wb=%0h want 1 3", ex_valid_o, ex_wb_o);
    end
  endtask

  task automatic test_load_use_excl();
    drive_idle();
    id_valid_i = 1; id_m_i = 3'b010; id_rt_i = 5'd0;
    tick();
    id_m_i = 3'b000; id_rs_i = 5'd0; id_rt_i = 5'd0;
    #1;
    n_checks++; if (hazard_stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_rt_zero got %0h want 0", hazard_stall_o); end
    id_m_i = 3'b010; id_rt_i = 5'd8;
    tick();
    id_m_i = 3'b000; id_rs_i = 5'd8; id_rt_i = 5'd2; id_valid_i = 0;
    #1;
    n_checks++; if (hazard_stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_id_invalid got %0h want 0", hazard_stall_o); end
    tick();
    drive_idle();
  endtask

  task automatic test_saturation();
    stall_i = 1; id_valid_i = 1; id_npc_i = 32'h900;
    tick();
    rst_n = 0;
    #1;
    n_checks++; if (ex_npc_o !== 32'h0 || bubble_cnt_o !== 16'h0 || s_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_in_stall got npc=%0h cnt=%0d scnt=%0d want 0 0 0", ex_npc_o, bubble_cnt_o, s_cnt);
    end
    tick();
    rst_n = 1;
    drive_idle();
    flush_i = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++; if (s_cnt !== ((i > 3) ? 2'd3 : 2'(i))) begin
        n_fail++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, s_cnt, (i > 3) ? 3 : i);
      end
      n_checks++; if (bubble_cnt_o !== 16'(i)) begin n_fail++; $display("FAIL wide_cnt[%0d] got %0d want %0d", i, bubble_cnt_o, i); end
    end
    flush_i = 0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_stall();
    test_flush_stall();
    test_load_use();
    test_load_use_excl();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
